// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// uart_rx_ctrl: bit-strobe generator, byte capture FIFO and interrupt for the UART receiver.
// Rev 1.0. Optional idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int DEPTH       = 4,
  parameter int IRQ_LEVEL   = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     RSTn,
  input  logic                     rx_en,
  input  logic [15:0]              baud_div,
  input  logic                     bps_en,
  output logic                     clk_uart,
  input  logic [7:0]               rx_data,
  input  logic                     rx_done,
  output logic [7:0]               rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  input  logic                     overrun_clr,
  output logic                     timeout,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] IRQ_CNT  = CW'(IRQ_LEVEL);

  logic [15:0]   div_eff;
  logic [15:0]   cnt;
  logic          rx_done_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          push;
  logic          pop;
  logic          wr;

  assign div_eff = (baud_div < 16'd2) ? 16'd2 : baud_div;

  // Reload to half a bit so the first strobe lands mid-bit; >= keeps a shrinking divisor from hanging.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      cnt      <= div_eff >> 1;
      clk_uart <= 1'b0;
    end else if (!bps_en || !rx_en) begin
      cnt      <= div_eff >> 1;
      clk_uart <= 1'b0;
    end else if (cnt >= div_eff - 16'd1) begin
      cnt      <= 16'd0;
      clk_uart <= 1'b1;
    end else begin
      cnt      <= cnt + 16'd1;
      clk_uart <= 1'b0;
    end
  end

  assign full     = (count == FULL_CNT);
  assign rd_valid = (count != '0);
  assign push     = rx_en & rx_done & ~rx_done_q;
  assign pop      = rd_valid & rd_ready;
  assign wr       = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      rx_done_q <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun   <= 1'b0;
    end else begin
      rx_done_q <= rx_done;
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign rd_data    = rd_valid ? mem[rd_ptr] : 8'h00;
  assign fifo_count = count;
  assign irq        = (count >= IRQ_CNT) | overrun | timeout;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYC);

  logic [TW-1:0] idle;

  // Timeout sets only on the step into saturation, so a clear while saturated sticks.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      idle    <= '0;
      timeout <= 1'b0;
    end else begin
      if (push || pop || !rd_valid) begin
        idle <= '0;
      end else if (idle != T_MAX) begin
        idle <= idle + 1'b1;
      end
      if (!push && !pop && rd_valid && (idle == T_MAX - 1'b1)) begin
        timeout <= 1'b1;
      end else if (pop || !rd_valid || overrun_clr) begin
        timeout <= 1'b0;
      end
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// tb_uart_rx_ctrl: directed and randomized stimulus against a queue-based reference model.
// Rev 1.0.
module tb_uart_rx_ctrl;

  localparam int DEPTH     = 4;
  localparam int IRQ_LEVEL = 1;
  localparam int TMO       = 64;

  logic        clk = 1'b0;
  logic        RSTn;
  logic        rx_en;
  logic [15:0] baud_div;
  logic        bps_en;
  logic        clk_uart;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [2:0]  fifo_count;
  logic        overrun;
  logic        overrun_clr;
  logic        timeout;
  logic        irq;

  uart_rx_ctrl #(.DEPTH(DEPTH), .IRQ_LEVEL(IRQ_LEVEL), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .RSTn(RSTn), .rx_en(rx_en), .baud_div(baud_div), .bps_en(bps_en),
    .clk_uart(clk_uart), .rx_data(rx_data), .rx_done(rx_done), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .fifo_count(fifo_count), .overrun(overrun),
    .overrun_clr(overrun_clr), .timeout(timeout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0] q[$];
  bit         ov_m, prev_m, to_m, exp_strobe;
  int         n_en, d_run, idle_m;
  int         total = 0;
  int         bad   = 0;
  int         strobes;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int deff(input int b);
    return (b < 2) ? 2 : b;
  endfunction

  // Model one rising edge from the inputs that were stable across it.
  task automatic model_edge();
    int  sz, first;
    bit  push, pop, empty_b;
    if (!RSTn) begin
      q.delete();
      ov_m = 0; prev_m = 0; to_m = 0; exp_strobe = 0; n_en = 0; idle_m = 0;
    end else begin
      if (bps_en && rx_en) begin
        if (n_en == 0) d_run = deff(int'(baud_div));
        n_en++;
        first      = d_run - d_run / 2;
        exp_strobe = (n_en >= first) && (((n_en - first) % d_run) == 0);
      end else begin
        n_en       = 0;
        exp_strobe = 0;
      end
      push    = rx_en && rx_done && !prev_m;
      prev_m  = rx_done;
      sz      = q.size();
      empty_b = (sz == 0);
      pop     = (sz > 0) && rd_ready;
      if (pop) void'(q.pop_front());
      if (push && (sz < DEPTH || pop)) q.push_back(rx_data);
      if (push && sz == DEPTH && !pop) ov_m = 1;
      else if (overrun_clr)            ov_m = 0;
`ifdef UART_RX_TIMEOUT_EN
      if (push || pop || empty_b) begin
        idle_m = 0;
        if (pop || empty_b || overrun_clr) to_m = 0;
      end else if (idle_m < TMO) begin
        idle_m++;
        if (idle_m == TMO) to_m = 1;
        else if (overrun_clr) to_m = 0;
      end else if (overrun_clr) begin
        to_m = 0;
      end
`else
      if (empty_b) idle_m = 0;
`endif
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = q.size();
    check("clk_uart",   clk_uart,   exp_strobe);
    check("rd_valid",   rd_valid,   sz > 0);
    check("fifo_count", fifo_count, sz);
    check("overrun",    overrun,    ov_m);
    check("timeout",    timeout,    to_m);
    check("irq",        irq,        (sz >= IRQ_LEVEL) || ov_m || to_m);
    if (sz > 0) check("rd_data", rd_data, q[0]);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1; cyc();
    rx_done = 1'b0; cyc();
  endtask

  initial begin
    RSTn = 1'b0; rx_en = 1'b0; baud_div = 16'd16; bps_en = 1'b0; rx_data = 8'h00;
    rx_done = 1'b0; rd_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) cyc();
    check("rst_rd_data", rd_data, 8'h00);
    RSTn = 1'b1; rx_en = 1'b1;
    cyc();

    // Strobe cadence: 160 enabled cycles at divisor 16
    strobes = 0;
    bps_en = 1'b1;
    repeat (160) begin cyc(); strobes += int'(clk_uart); end
    bps_en = 1'b0;
    repeat (20) begin cyc(); strobes += int'(clk_uart); end
    check("strobe_total", strobes, 10);

    // Wide rx_done gives a single push
    rx_data = 8'hA5; rx_done = 1'b1;
    repeat (3) cyc();
    rx_done = 1'b0;
    check("wide_done_cnt", fifo_count, 1);
    check("wide_done_dat", rd_data, 8'hA5);
    cyc();
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;

    // Overflow, drain order, overrun clear
    for (int i = 1; i <= 5; i++) push_byte(8'(i));
    check("ovr_set", overrun, 1'b1);
    check("ovr_cnt", fifo_count, 4);
    rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin check("drain", rd_data, i); cyc(); end
    rd_ready = 1'b0;
    overrun_clr = 1'b1; cyc(); overrun_clr = 1'b0;
    check("ovr_clr", overrun, 1'b0);
    check("irq_clr", irq, 1'b0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) push_byte(8'(8'h10 + i));
    rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1; cyc();
    rx_done = 1'b0; rd_ready = 1'b0;
    check("full_pp_cnt", fifo_count, 4);
    check("full_pp_ovr", overrun, 1'b0);
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("last77", rd_data, 8'h77);
      cyc();
    end
    rd_ready = 1'b0;

    // Minimum divisor, then reset mid-stream
    baud_div = 16'd0; cyc();
    bps_en = 1'b1;
    rx_data = 8'h5A; rx_done = 1'b1;
    repeat (12) cyc();
    RSTn = 1'b0; cyc();
    check("rst_valid", rd_valid, 1'b0);
    check("rst_strobe", clk_uart, 1'b0);
    RSTn = 1'b1; bps_en = 1'b0; rx_done = 1'b0; cyc();

`ifdef UART_RX_TIMEOUT_EN
    push_byte(8'h3C);
    repeat (70) cyc();
    check("tmo_set", timeout, 1'b1);
    rd_ready = 1'b1; cyc(); rd_ready = 1'b0;
    check("tmo_clr", timeout, 1'b0);
`endif

    // Randomized traffic
    baud_div = 16'($urandom_range(0, 24)); cyc();
    repeat (3000) begin
      rx_en       = ($urandom % 8) != 0;
      rx_done     = ($urandom % 3) == 0;
      rx_data     = 8'($urandom);
      rd_ready    = ($urandom % 3) == 0;
      overrun_clr = ($urandom % 20) == 0;
      RSTn        = ($urandom % 500) != 0;
      if (!bps_en && ($urandom % 4) == 0)       bps_en = 1'b1;
      else if (bps_en && ($urandom % 64) == 0)  bps_en = 1'b0;
      else if (!bps_en)                         baud_div = 16'($urandom_range(0, 24));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
